cpu_control_fsm: RTL and testbench

//  Multi-cycle fetch/decode/control sequencer for the 8-bit, 4-register CPU.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_control_fsm_if.sv | 34 +++
 rtl/cpu_imm_sext.sv | 21 ++
 rtl/cpu_control_fsm.sv | 144 ++++++++++++++
 tb/tb_cpu_control_fsm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//  Shared definitions for the 8-bit, 4-register CPU control path:
//  instruction/select widths, opcode encodings, sequencer state encoding
//  and a helper to pull the opcode field out of an instruction word.
//  No ports (package).
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int INSTR_W   = 8;
   localparam int REG_SEL_W = 2;

   typedef logic [1:0] opcode_t;

   localparam opcode_t OP_ADD = 2'b00;
   localparam opcode_t OP_LW  = 2'b01;
   localparam opcode_t OP_SW  = 2'b10;
   localparam opcode_t OP_J   = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_t;

   function automatic opcode_t instr_op(input logic [INSTR_W-1:0] instr);
      return instr[7:6];
   endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// ----------------------------------------------------------------------------
// cpu_control_fsm_if
//  Instruction-fetch bus between the control sequencer (master) and the
//  instruction memory (slave).
//   InstrReq    master->slave  fetch request, held until InstrValid
//   InstrAddr   master->slave  fetch address (current PC)
//   InstrIn     slave->master  instruction read data
//   InstrValid  slave->master  InstrIn valid for the current InstrAddr
// ----------------------------------------------------------------------------
interface cpu_control_fsm_if #(
   parameter int PC_WIDTH = 8
);
   import cpu_pkg::*;

   logic                InstrReq;
   logic [PC_WIDTH-1:0] InstrAddr;
   logic [INSTR_W-1:0]  InstrIn;
   logic                InstrValid;

   modport master (
      output InstrReq,
      output InstrAddr,
      input  InstrIn,
      input  InstrValid
   );

   modport slave (
      input  InstrReq,
      input  InstrAddr,
      output InstrIn,
      output InstrValid
   );

endinterface

// File: rtl/cpu_imm_sext.sv
// ----------------------------------------------------------------------------
// cpu_imm_sext
//  Sign extension of the two immediate fields of an instruction word.
//   imm2   in   2        load/store displacement field IR[1:0]
//   imm6   in   6        jump offset field IR[5:0]
//   sext2  out  INSTR_W  imm2 sign-extended
//   sext6  out  INSTR_W  imm6 sign-extended
// ----------------------------------------------------------------------------
module cpu_imm_sext
   import cpu_pkg::*;
(
   input  logic        [1:0]         imm2,
   input  logic        [5:0]         imm6,
   output logic signed [INSTR_W-1:0] sext2,
   output logic signed [INSTR_W-1:0] sext6
);

   assign sext2 = {{(INSTR_W-2){imm2[1]}}, imm2};
   assign sext6 = {{(INSTR_W-6){imm6[5]}}, imm6};

endmodule

// File: rtl/cpu_control_fsm.sv
// ----------------------------------------------------------------------------
// cpu_control_fsm
//  Multi-cycle fetch/decode/control sequencer. Holds PC and IR, fetches
//  over the instruction bus and drives register-file selects and the
//  ALU / data-memory control lines.
//   CLK        in   1         rising-edge clock
//   Reset      in   1         synchronous, active-low reset
//   Run        in   1         1 = execute, 0 = stop at next instruction end
//   ibus       master         instruction fetch bus (req/addr/data/valid)
//   ReadSel1   out  2         register read select 1 (rs)
//   ReadSel2   out  2         register read select 2 (rt)
//   WriteSel   out  2         register write destination
//   RegWrite   out  1         register write enable, one-cycle pulse in WB
//   ALUSrc     out  1         0 = rt operand, 1 = Imm
//   MemRead    out  1         data memory read strobe
//   MemWrite   out  1         data memory write strobe
//   MemToReg   out  1         writeback source: 0 = ALU, 1 = memory
//   Imm        out  8         sign-extended immediate
//   Busy       out  1         1 whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module cpu_control_fsm
   import cpu_pkg::*;
#(
   parameter int                  PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                 CLK,
   input  logic                 Reset,
   input  logic                 Run,
   cpu_control_fsm_if.master    ibus,
   output logic [REG_SEL_W-1:0] ReadSel1,
   output logic [REG_SEL_W-1:0] ReadSel2,
   output logic [REG_SEL_W-1:0] WriteSel,
   output logic                 RegWrite,
   output logic                 ALUSrc,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 MemToReg,
   output logic [INSTR_W-1:0]   Imm,
   output logic                 Busy
);

   state_t              state, state_d;
   logic [PC_WIDTH-1:0] pc, pc_d;
   logic [INSTR_W-1:0]  ir, ir_d;
   logic                instr_req;
   opcode_t             op;

   logic signed [INSTR_W-1:0] sext2;
   logic signed [INSTR_W-1:0] sext6;

   assign op = instr_op(ir);

   cpu_imm_sext u_imm_sext (
      .imm2  (ir[1:0]),
      .imm6  (ir[5:0]),
      .sext2 (sext2),
      .sext6 (sext6)
   );

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state <= IDLE;
         pc    <= RESET_PC;
         ir    <= '0;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         ir    <= ir_d;
      end
   end

   // Strobes are decoded purely from state, so a reset that lands while an
   // instruction is in flight returns to IDLE before any pending strobe fires.
   always_comb begin
      state_d   = state;
      pc_d      = pc;
      ir_d      = ir;
      instr_req = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ALUSrc    = 1'b0;
      MemToReg  = 1'b0;

      case (state)
         IDLE: begin
            if (Run) state_d = FETCH;
         end
         FETCH: begin
            instr_req = 1'b1;
            if (ibus.InstrValid) begin
               ir_d    = ibus.InstrIn;
               pc_d    = pc + PC_WIDTH'(1);
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (op == OP_J) begin
               // pc already holds PC_next here; the add wraps modulo 2^PC_WIDTH
               pc_d    = pc + PC_WIDTH'(sext6);
               state_d = Run ? FETCH : IDLE;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            ALUSrc  = (op == OP_LW) || (op == OP_SW);
            state_d = (op == OP_ADD) ? WB : MEM;
         end
         MEM: begin
            // address computation must stay on the immediate while memory is strobed
            ALUSrc = 1'b1;
            if (op == OP_LW) begin
               MemRead = 1'b1;
               state_d = WB;
            end else begin
               MemWrite = 1'b1;
               state_d  = Run ? FETCH : IDLE;
            end
         end
         WB: begin
            RegWrite = 1'b1;
            MemToReg = (op == OP_LW);
            state_d  = Run ? FETCH : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ibus.InstrReq  = instr_req;
   assign ibus.InstrAddr = pc;

   // Selects and immediate come straight from IR, so they hold steady from
   // DECODE through WB and read as zero after reset (IR cleared).
   assign ReadSel1 = ir[5:4];
   assign ReadSel2 = ir[3:2];
   assign WriteSel = (op == OP_LW) ? ir[3:2] : ir[1:0];
   assign Imm      = (op == OP_J) ? sext6 : sext2;
   assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_cpu_control_fsm
//  Directed-vector bench for cpu_control_fsm. Expected values are hand
//  computed from the instruction encodings and the state sequence.
// ----------------------------------------------------------------------------
module tb_cpu_control_fsm;
   import cpu_pkg::*;

   logic       CLK;
   logic       Reset;
   logic       Run;
   logic [1:0] ReadSel1, ReadSel2, WriteSel;
   logic       RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Busy;
   logic [7:0] Imm;

   int n_vec = 0;
   int n_err = 0;

   cpu_control_fsm_if #(.PC_WIDTH(8)) ibus ();

   cpu_control_fsm #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .Run      (Run),
      .ibus     (ibus),
      .ReadSel1 (ReadSel1),
      .ReadSel2 (ReadSel2),
      .WriteSel (WriteSel),
      .RegWrite (RegWrite),
      .ALUSrc   (ALUSrc),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .MemToReg (MemToReg),
      .Imm      (Imm),
      .Busy     (Busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present an instruction for one cycle while in FETCH and step into DECODE.
   task automatic give(input logic [7:0] instr);
      ibus.InstrIn    = instr;
      ibus.InstrValid = 1'b1;
      tick();
      ibus.InstrValid = 1'b0;
   endtask

   initial begin
      Reset           = 1'b0;
      Run             = 1'b1;
      ibus.InstrIn    = 8'h00;
      ibus.InstrValid = 1'b0;

      // 1. reset held two cycles with Run=1
      tick();
      tick();
      chk("rst_busy",     32'(Busy),           0);
      chk("rst_pc",       32'(ibus.InstrAddr), 32'h00);
      chk("rst_req",      32'(ibus.InstrReq),  0);
      chk("rst_regwr",    32'(RegWrite),       0);
      chk("rst_memrd",    32'(MemRead),        0);
      chk("rst_memwr",    32'(MemWrite),       0);
      chk("rst_sel1",     32'(ReadSel1),       0);
      chk("rst_wsel",     32'(WriteSel),       0);
      chk("rst_imm",      32'(Imm),            0);
      Reset = 1'b1;
      tick();
      chk("fetch_req",    32'(ibus.InstrReq),  1);
      chk("fetch_busy",   32'(Busy),           1);
      chk("fetch_addr",   32'(ibus.InstrAddr), 32'h00);

      // 2. ADD r3 = r1 + r2
      give(8'b00_01_10_11);
      chk("add_dec_sel1", 32'(ReadSel1),       1);
      chk("add_dec_sel2", 32'(ReadSel2),       2);
      chk("add_dec_rw",   32'(RegWrite),       0);
      chk("add_dec_req",  32'(ibus.InstrReq),  0);
      chk("add_pc",       32'(ibus.InstrAddr), 32'h01);
      tick();
      chk("add_ex_alusrc",32'(ALUSrc),         0);
      chk("add_ex_rw",    32'(RegWrite),       0);
      tick();
      chk("add_wb_rw",    32'(RegWrite),       1);
      chk("add_wb_wsel",  32'(WriteSel),       3);
      chk("add_wb_m2r",   32'(MemToReg),       0);
      chk("add_wb_sel1",  32'(ReadSel1),       1);
      tick();
      chk("add_end_rw",   32'(RegWrite),       0);
      chk("add_end_req",  32'(ibus.InstrReq),  1);
      chk("add_end_addr", 32'(ibus.InstrAddr), 32'h01);

      // 3. LW r1 = M[r0 + (-1)]
      give(8'b01_00_01_11);
      chk("lw_imm",       32'(Imm),            32'hFF);
      chk("lw_sel1",      32'(ReadSel1),       0);
      tick();
      chk("lw_ex_alusrc", 32'(ALUSrc),         1);
      chk("lw_ex_memrd",  32'(MemRead),        0);
      tick();
      chk("lw_mem_memrd", 32'(MemRead),        1);
      chk("lw_mem_rw",    32'(RegWrite),       0);
      tick();
      chk("lw_wb_rw",     32'(RegWrite),       1);
      chk("lw_wb_wsel",   32'(WriteSel),       1);
      chk("lw_wb_m2r",    32'(MemToReg),       1);
      chk("lw_wb_memrd",  32'(MemRead),        0);
      tick();
      chk("lw_end_addr",  32'(ibus.InstrAddr), 32'h02);

      // J at 02 with offset -5: 03 - 5 = FE
      give(8'b11_111011);
      chk("j1_imm",       32'(Imm),            32'hFB);
      chk("j1_pcnext",    32'(ibus.InstrAddr), 32'h03);
      tick();
      chk("j1_target",    32'(ibus.InstrAddr), 32'hFE);
      chk("j1_req",       32'(ibus.InstrReq),  1);

      // 4. J at FE with offset +3: FF + 3 wraps to 02
      give(8'b11_000011);
      chk("j2_pcnext",    32'(ibus.InstrAddr), 32'hFF);
      chk("j2_rw",        32'(RegWrite),       0);
      chk("j2_mw",        32'(MemWrite),       0);
      tick();
      chk("j2_target",    32'(ibus.InstrAddr), 32'h02);
      chk("j2_end_rw",    32'(RegWrite),       0);
      chk("j2_end_mw",    32'(MemWrite),       0);

      // 5. SW M[r1 + 1] = r2 with InstrValid delayed three cycles
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("sw_wait%0d_req", i),  32'(ibus.InstrReq),  1);
         chk($sformatf("sw_wait%0d_addr", i), 32'(ibus.InstrAddr), 32'h02);
         tick();
      end
      chk("sw_acc_req",   32'(ibus.InstrReq),  1);
      give(8'b10_01_10_01);
      chk("sw_sel1",      32'(ReadSel1),       1);
      chk("sw_sel2",      32'(ReadSel2),       2);
      chk("sw_imm",       32'(Imm),            32'h01);
      tick();
      chk("sw_ex_alusrc", 32'(ALUSrc),         1);
      chk("sw_ex_mw",     32'(MemWrite),       0);
      tick();
      chk("sw_mem_mw",    32'(MemWrite),       1);
      chk("sw_mem_rw",    32'(RegWrite),       0);
      chk("sw_mem_mr",    32'(MemRead),        0);
      tick();
      chk("sw_end_mw",    32'(MemWrite),       0);
      chk("sw_end_rw",    32'(RegWrite),       0);
      chk("sw_end_addr",  32'(ibus.InstrAddr), 32'h03);

      // 6. reset during EXEC of an ADD suppresses the WB pulse
      give(8'b00_01_10_11);
      tick();
      chk("rstx_in_exec", 32'(Busy),           1);
      Reset = 1'b0;
      tick();
      chk("rstx_rw",      32'(RegWrite),       0);
      chk("rstx_busy",    32'(Busy),           0);
      chk("rstx_pc",      32'(ibus.InstrAddr), 32'h00);
      chk("rstx_req",     32'(ibus.InstrReq),  0);
      chk("rstx_sel1",    32'(ReadSel1),       0);
      chk("rstx_wsel",    32'(WriteSel),       0);
      Reset = 1'b1;
      tick();
      chk("rstx_fetch",   32'(ibus.InstrReq),  1);

      // 7. Run dropped in DECODE of ADD r2 = r3 + r0; InstrValid outside FETCH ignored
      give(8'b00_11_00_10);
      Run = 1'b0;
      tick();
      ibus.InstrIn    = 8'hC0;
      ibus.InstrValid = 1'b1;
      tick();
      ibus.InstrValid = 1'b0;
      chk("run_wb_rw",    32'(RegWrite),       1);
      chk("run_wb_wsel",  32'(WriteSel),       2);
      chk("run_wb_sel1",  32'(ReadSel1),       3);
      tick();
      chk("run_idle_busy",32'(Busy),           0);
      chk("run_idle_req", 32'(ibus.InstrReq),  0);
      chk("run_idle_rw",  32'(RegWrite),       0);
      chk("run_idle_pc",  32'(ibus.InstrAddr), 32'h01);
      tick();
      chk("run_stay_busy",32'(Busy),           0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
